// File: rtl/activation_repacker.sv
// rtl/activation_repacker.sv - buffers one image-major activation frame and replays it neuron-major.
// Three images of NUM_NEURONS values each are stored, then drained as one {img2,img1,img0} beat per neuron.
module activation_repacker #(
    parameter int NUM_NEURONS = 160,
    parameter int BITWIDTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [BITWIDTH-1:0]     a_tdata,
    input  logic                    a_tvalid,
    output logic                    a_tready,
    output logic [3*BITWIDTH-1:0]   x_tdata,
    output logic                    x_tvalid,
    input  logic                    x_tready,
    output logic [1:0]              status,
    output logic                    frame_done
);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state_q;
    logic [NW-1:0]           n_cnt_q;
    logic [1:0]              img_cnt_q;
    logic [NW-1:0]           d_cnt_q;
    logic                    a_tready_q;
    logic                    x_tvalid_q;
    logic [3*BITWIDTH-1:0]   x_tdata_q;
    logic                    frame_done_q;

    logic [BITWIDTH-1:0]     mem0 [NUM_NEURONS];
    logic [BITWIDTH-1:0]     mem1 [NUM_NEURONS];
    logic [BITWIDTH-1:0]     mem2 [NUM_NEURONS];

    logic                    a_hs;
    logic                    x_hs;
    logic                    last_fill;
    logic                    last_drain;
    logic [NW-1:0]           d_cnt_d;
    logic [BITWIDTH-1:0]     first_img2;
    logic [3*BITWIDTH-1:0]   first_beat;
    logic [3*BITWIDTH-1:0]   next_beat;

    always_comb begin
        a_hs       = (state_q == FILL) && a_tvalid && a_tready_q;
        x_hs       = (state_q == DRAIN) && x_tvalid_q && x_tready;
        last_fill  = a_hs && (img_cnt_q == 2'd2) && (n_cnt_q == LAST_N);
        last_drain = x_hs && (d_cnt_q == LAST_N);
        d_cnt_d    = d_cnt_q + NW'(1);
        // The final fill write lands on the same edge as the first beat load, so bypass it.
        first_img2 = (NUM_NEURONS == 1) ? a_tdata : mem2[0];
        first_beat = {first_img2, mem1[0], mem0[0]};
        next_beat  = {mem2[d_cnt_d], mem1[d_cnt_d], mem0[d_cnt_d]};
    end

    always_ff @(posedge CLK) begin
        if (a_hs) begin
            case (img_cnt_q)
                2'd0:    mem0[n_cnt_q] <= a_tdata;
                2'd1:    mem1[n_cnt_q] <= a_tdata;
                default: mem2[n_cnt_q] <= a_tdata;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= FILL;
            n_cnt_q      <= '0;
            img_cnt_q    <= '0;
            d_cnt_q      <= '0;
            a_tready_q   <= 1'b0;
            x_tvalid_q   <= 1'b0;
            x_tdata_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                FILL: begin
                    a_tready_q <= 1'b1;
                    if (a_hs) begin
                        if (last_fill) begin
                            state_q    <= DRAIN;
                            a_tready_q <= 1'b0;
                            n_cnt_q    <= '0;
                            img_cnt_q  <= '0;
                            d_cnt_q    <= '0;
                            x_tvalid_q <= 1'b1;
                            x_tdata_q  <= first_beat;
                        end else if (n_cnt_q == LAST_N) begin
                            n_cnt_q   <= '0;
                            img_cnt_q <= img_cnt_q + 2'd1;
                        end else begin
                            n_cnt_q <= n_cnt_q + NW'(1);
                        end
                    end
                end
                DRAIN: begin
                    a_tready_q <= 1'b0;
                    if (last_drain) begin
                        state_q      <= FILL;
                        x_tvalid_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        d_cnt_q      <= '0;
                        n_cnt_q      <= '0;
                        img_cnt_q    <= '0;
                        a_tready_q   <= 1'b1;
                    end else if (x_hs) begin
                        d_cnt_q   <= d_cnt_d;
                        x_tdata_q <= next_beat;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign a_tready   = a_tready_q;
    assign x_tvalid   = x_tvalid_q;
    assign x_tdata    = x_tdata_q;
    assign frame_done = frame_done_q;
    assign status     = (state_q == DRAIN) ? 2'b10 :
                        ((img_cnt_q == 2'd0) && (n_cnt_q == '0)) ? 2'b00 : 2'b01;

endmodule

// File: tb/tb_activation_repacker.sv
// tb/tb_activation_repacker.sv - randomized self-checking bench for activation_repacker.
// Expected beats come from a frame array: beat n = {frame[2N+n], frame[N+n], frame[n]}.
module tb_activation_repacker;
    localparam int N = 160;
    localparam int B = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [B-1:0]   a_tdata = '0;
    logic           a_tvalid = 1'b0;
    logic           a_tready;
    logic [3*B-1:0] x_tdata;
    logic           x_tvalid;
    logic           x_tready = 1'b0;
    logic [1:0]     status;
    logic           frame_done;

    activation_repacker #(.NUM_NEURONS(N), .BITWIDTH(B)) dut (
        .CLK(CLK), .RST(RST),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .status(status), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [B-1:0]   frame [3*N];
    logic [3*B-1:0] exp_beats [N];
    logic [3*B-1:0] got [$];
    int             status_seq [$];
    int             done_cnt, done_beat, lat, stall_bad, extra_acc, timeout;
    bit             ready_at_done;

    function automatic void build_expected();
        for (int n = 0; n < N; n++)
            exp_beats[n] = {frame[2*N+n], frame[N+n], frame[n]};
    endfunction

    function automatic void fill_pattern();
        for (int i = 0; i < 3*N; i++) frame[i] = B'(i % 16);
        build_expected();
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < 3*N; i++) frame[i] = B'($urandom_range(15));
        build_expected();
    endfunction

    task automatic run_frame(input int gap_pct, input bit bp, input bit junk);
        int fidx = 0;
        int cyc = 0;
        int bp_i = 0;
        int last_fill = -1;
        int first_xv = -1;
        bit prev_stall = 0;
        logic [3*B-1:0] prev_data = '0;
        got.delete(); status_seq.delete();
        done_cnt = 0; done_beat = -1; lat = -1; stall_bad = 0;
        extra_acc = 0; timeout = 0; ready_at_done = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (status_seq.size() == 0) status_seq.push_back(int'(status));
            else if (status_seq[$] != int'(status)) status_seq.push_back(int'(status));
            if (x_tvalid && first_xv < 0) first_xv = cyc;
            if (prev_stall && (x_tvalid !== 1'b1 || x_tdata !== prev_data)) stall_bad++;
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_beat = got.size();
                ready_at_done = (a_tready === 1'b1) && (x_tvalid === 1'b0);
                a_tvalid = 1'b0; x_tready = 1'b0;
                break;
            end
            if (cyc > 4000) begin
                timeout = 1; a_tvalid = 1'b0; x_tready = 1'b0;
                break;
            end
            if (fidx < 3*N) begin
                a_tvalid = ($urandom_range(99) >= gap_pct);
                a_tdata  = frame[fidx];
            end else begin
                a_tvalid = junk;
                a_tdata  = 4'hF;
            end
            if (a_tvalid && a_tready) begin
                if (fidx < 3*N) begin
                    fidx++;
                    if (fidx == 3*N) last_fill = cyc;
                end else extra_acc++;
            end
            if (bp && x_tvalid) begin
                x_tready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
                bp_i++;
            end else x_tready = 1'b1;
            if (x_tvalid && x_tready) got.push_back(x_tdata);
            prev_stall = x_tvalid && !x_tready;
            prev_data  = x_tdata;
        end
        if (last_fill >= 0 && first_xv >= 0) lat = first_xv - last_fill;
    endtask

    task automatic test_reset();
        RST = 1'b1; a_tvalid = 1'b1; a_tdata = 4'h5; x_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (a_tready !== 1'b0 || x_tvalid !== 1'b0 || x_tdata !== '0 || status !== 2'b00 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: a_tready=%b x_tvalid=%b x_tdata=%h status=%b frame_done=%b, want 0 0 000 00 0",
                         i, a_tready, x_tvalid, x_tdata, status, frame_done);
            end
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (a_tready !== 1'b1 || status !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: a_tready=%b status=%b, want 1 00", a_tready, status);
        end
        a_tvalid = 1'b0;
    endtask

    task automatic test_full_frame();
        int nbad = 0;
        int first_bad = -1;
        fill_pattern();
        run_frame(0, 0, 0);
        checks++;
        if (timeout != 0 || got.size() != N) begin
            errors++;
            $display("FAIL full_beat_count: got %0d beats timeout=%0d, want %0d", got.size(), timeout, N);
        end
        for (int n = 0; n < N && n < got.size(); n++)
            if (got[n] !== exp_beats[n]) begin nbad++; if (first_bad < 0) first_bad = n; end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL full_beats: %0d wrong, first at %0d got %h want %h", nbad, first_bad, got[first_bad], exp_beats[first_bad]);
        end
        checks++;
        if (got.size() < 2 || got[0] !== 12'h000 || got[1] !== 12'h111) begin
            errors++;
            $display("FAIL full_first_beats: got %h %h, want 000 111",
                     got.size() > 0 ? got[0] : 12'hxxx, got.size() > 1 ? got[1] : 12'hxxx);
        end
        checks++;
        if (done_cnt != 1 || done_beat != N) begin
            errors++;
            $display("FAIL full_frame_done: pulses=%0d after beat count %0d, want 1 after %0d", done_cnt, done_beat, N);
        end
        checks++;
        if (status_seq.size() != 4 || status_seq[0] != 0 || status_seq[1] != 1 || status_seq[2] != 2 || status_seq[3] != 0) begin
            errors++;
            $display("FAIL full_status_seq: got %p, want 0 1 2 0", status_seq);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL full_fill_to_drain_latency: got %0d cycles, want 1", lat);
        end
        checks++;
        if (!ready_at_done) begin
            errors++;
            $display("FAIL full_drain_to_fill: a_tready/x_tvalid at frame_done wrong, want a_tready=1 x_tvalid=0");
        end
    endtask

    task automatic test_backpressure();
        int nbad = 0;
        fill_random();
        run_frame(0, 1, 0);
        for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
        checks++;
        if (timeout != 0 || got.size() != N || nbad != 0) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats with %0d wrong, want %0d beats with 0 wrong", got.size(), nbad, N);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall_hold: %0d stalled cycles changed x_tdata/x_tvalid, want 0", stall_bad);
        end
        checks++;
        if (done_cnt != 1 || done_beat != N) begin
            errors++;
            $display("FAIL bp_frame_done: pulses=%0d at beat %0d, want 1 at %0d", done_cnt, done_beat, N);
        end
    endtask

    task automatic test_upstream_gaps();
        int nbad = 0;
        fill_random();
        run_frame(30, 0, 0);
        for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
        checks++;
        if (timeout != 0 || got.size() != N || nbad != 0) begin
            errors++;
            $display("FAIL gaps_beats: got %0d beats with %0d wrong, want %0d beats with 0 wrong", got.size(), nbad, N);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL gaps_latency: got %0d, want 1", lat);
        end
    endtask

    task automatic test_ignored_input();
        int nbad = 0;
        fill_random();
        run_frame(0, 1, 1);
        checks++;
        if (extra_acc != 0) begin
            errors++;
            $display("FAIL ignore_no_accept: %0d a handshakes during drain, want 0", extra_acc);
        end
        for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
        checks++;
        if (timeout != 0 || got.size() != N || nbad != 0) begin
            errors++;
            $display("FAIL ignore_beats: got %0d beats with %0d wrong, want %0d with 0 wrong", got.size(), nbad, N);
        end
        nbad = 0;
        fill_random();
        run_frame(10, 0, 0);
        for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
        checks++;
        if (got.size() == 0 || got[0][B-1:0] !== frame[0]) begin
            errors++;
            $display("FAIL ignore_next_first: got %h, want low nibble %h", got.size() > 0 ? got[0] : 12'hxxx, frame[0]);
        end
        checks++;
        if (timeout != 0 || got.size() != N || nbad != 0) begin
            errors++;
            $display("FAIL ignore_next_frame: got %0d beats with %0d wrong, want %0d with 0 wrong", got.size(), nbad, N);
        end
    endtask

    task automatic test_reset_mid_fill();
        int acc = 0;
        int cyc = 0;
        int nbad = 0;
        while (acc < 200 && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            a_tvalid = 1'b1;
            a_tdata  = B'($urandom_range(15));
            x_tready = 1'b1;
            if (a_tready) acc++;
        end
        @(negedge CLK);
        a_tvalid = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (acc != 200 || status !== 2'b00 || a_tready !== 1'b1 || x_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: acc=%0d status=%b a_tready=%b x_tvalid=%b, want 200 00 1 0", acc, status, a_tready, x_tvalid);
        end
        fill_random();
        run_frame(0, 0, 0);
        for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
        checks++;
        if (timeout != 0 || got.size() != N || nbad != 0) begin
            errors++;
            $display("FAIL midreset_beats: got %0d beats with %0d wrong, want %0d with 0 wrong", got.size(), nbad, N);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            int nbad = 0;
            fill_random();
            run_frame(0, 0, 0);
            for (int n = 0; n < N && n < got.size(); n++) if (got[n] !== exp_beats[n]) nbad++;
            checks++;
            if (timeout != 0 || got.size() != N || nbad != 0) begin
                errors++;
                $display("FAIL b2b_beats f%0d: got %0d beats with %0d wrong, want %0d with 0 wrong", f, got.size(), nbad, N);
            end
            checks++;
            if (lat != 1 || !ready_at_done || done_cnt != 1) begin
                errors++;
                $display("FAIL b2b_transitions f%0d: latency=%0d ready_at_done=%0d pulses=%0d, want 1 1 1", f, lat, ready_at_done, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_upstream_gaps();
        test_ignored_input();
        test_reset_mid_fill();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
